// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq_if
//  Description : Request/result bundle for the sequential multiply/divide unit.
//                The master issues operations; the slave (muldiv_seq) returns
//                status and results.
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] productHI;
  logic [WIDTH-1:0] productLO;
  logic             div_by_zero;

  modport master (
    output start, op, opA, opB,
    input  busy, done, productHI, productLO, div_by_zero
  );

  modport slave (
    input  start, op, opA, opB,
    output busy, done, productHI, productLO, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative multiply/divide unit. One shift-add (multiply) or
//                restoring-subtract (divide) step per cycle on operand
//                magnitudes, followed by a sign-fix cycle. Signed and
//                unsigned variants of both operations; divide-by-zero is
//                short-circuited.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  muldiv_seq_if.slave io_bus
);

  localparam int                 c_cnt_w   = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_is_div;
  logic                 r_neg_lo;    // product sign (mult) or quotient sign (div)
  logic                 r_neg_hi;    // remainder sign (div only)
  logic                 r_dbz_pend;
  logic [WIDTH-1:0]     r_hi;        // running upper half / partial remainder
  logic [WIDTH-1:0]     r_lo;        // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0]     r_b;         // multiplicand or divisor magnitude
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic [WIDTH-1:0]     r_prod_hi;
  logic [WIDTH-1:0]     r_prod_lo;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_dbz;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_neg;

  // Operand magnitudes; op[0] selects signed interpretation.
  assign w_a_neg = io_bus.op[0] & io_bus.opA[WIDTH-1];
  assign w_b_neg = io_bus.op[0] & io_bus.opB[WIDTH-1];
  assign w_a_mag = w_a_neg ? -io_bus.opA : io_bus.opA;
  assign w_b_mag = w_b_neg ? -io_bus.opB : io_bus.opB;
  assign w_dbz   = io_bus.op[1] && (io_bus.opB == '0);

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right with the carry.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Restoring-divide step. The remainder is always below the divisor, so the
  // difference fits in WIDTH bits whenever the trial subtraction succeeds.
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, r_b});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_neg = -w_prod;

  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.productHI   = r_prod_hi;
  assign io_bus.productLO   = r_prod_lo;
  assign io_bus.div_by_zero = r_dbz;

  // Control FSM and datapath; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_prod_hi  <= '0;
      r_prod_lo  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_dbz  <= 1'b0;
          if (io_bus.start) begin
            r_is_div <= io_bus.op[1];
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
            if (w_dbz) begin
              // No iterations: FIX copies these straight to the outputs.
              r_hi       <= io_bus.opA;
              r_lo       <= '1;
              r_b        <= '0;
              r_neg_lo   <= 1'b0;
              r_neg_hi   <= 1'b0;
              r_dbz_pend <= 1'b1;
              r_count    <= '0;
            end else begin
              r_hi       <= '0;
              r_lo       <= w_a_mag;
              r_b        <= w_b_mag;
              r_neg_lo   <= w_a_neg ^ w_b_neg;
              r_neg_hi   <= io_bus.op[1] & w_a_neg;
              r_dbz_pend <= 1'b0;
              r_count    <= c_cnt_max;
            end
          end
        end

        S_CALC: begin
          if (r_count != '0) begin
            r_count <= r_count - c_cnt_one;
            if (r_is_div) begin
              r_hi <= w_fits ? w_diff : w_rem_sh[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], w_fits};
            end else begin
              r_hi <= w_sum[WIDTH:1];
              r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
          end else begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_is_div) begin
            r_prod_hi <= r_neg_hi ? -r_hi : r_hi;
            r_prod_lo <= r_neg_lo ? -r_lo : r_lo;
          end else begin
            {r_prod_hi, r_prod_lo} <= r_neg_lo ? w_prod_neg : w_prod;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dbz   <= r_dbz_pend;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_dbz   <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits (WIDTH >= 4).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only when busy=0.
REQ-005 op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
REQ-006 opA  input  WIDTH  multiplicand / dividend.
REQ-007 opB  input  WIDTH  multiplier / divisor.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse: productHI/productLO valid and updated.
REQ-010 productHI  output  WIDTH  mult: upper product half; div: remainder.
REQ-011 productLO  output  WIDTH  mult: lower product half; div: quotient.
REQ-012 div_by_zero  output  1  pulses with done when a DIVU/DIV had opB=0; otherwise 0.

Function
REQ-013 FSM states: IDLE, CALC, FIX, DONE; the block SHALL be in exactly one of them at all times.
REQ-014 IDLE: start=1 at a rising edge latches op, opA, opB; signed ops store operand magnitudes and result/remainder signs; count loads WIDTH; next state CALC; busy=1 from the following cycle.
REQ-015 CALC: one iteration per cycle (shift-add multiply; restoring divide on magnitudes); count decrements; after WIDTH iterations, next state FIX.
REQ-016 FIX: apply sign correction (two's-complement negate of the 2*WIDTH product, or of quotient/remainder as required), then write productHI/productLO; next state DONE.
REQ-017 DONE: done=1 and busy=0 for exactly one cycle; next state IDLE; start in DONE is ignored.
REQ-018 Latency: for a start sampled at edge 0, done SHALL be high in the cycle after edge WIDTH+2, with results valid in that same cycle.
REQ-019 productHI/productLO SHALL hold their last value between operations and SHALL NOT change during CALC.
REQ-020 start while busy=1 SHALL be ignored; operand/op changes during busy SHALL NOT affect the running operation.
REQ-021 Multiply: the full 2*WIDTH-bit product; MULT of the most-negative value by itself SHALL yield the exact positive product.
REQ-022 Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend; most-negative / -1 SHALL give LO=most-negative (wrap), HI=0.
REQ-023 Divide by zero (op[1]=1, opB=0): detected in IDLE, CALC skipped, FIX writes HI=opA, LO=all ones; done and div_by_zero pulse two cycles after the start edge.

Reset
REQ-024 While reset=1 at a rising edge: state IDLE, busy=0, done=0, div_by_zero=0, productHI=0, productLO=0, count=0.
REQ-025 Reset asserted mid-operation SHALL abort it with no done pulse; start sampled in the same cycle as reset=1 SHALL be ignored.
REQ-026 The first start after reset deassertion SHALL be accepted normally.

Verification (WIDTH=32 unless stated)
REQ-027 MULTU opA=20, opB=0xFFFFFFE2 -> done exactly 34 cycles after start edge; HI=0x00000013, LO=0xFFFFFDA8.
REQ-028 MULT opA=20, opB=-30 -> HI=0xFFFFFFFF, LO=0xFFFFFDA8; DIVU 7/2 -> LO=0x3, HI=0x1; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-029 DIVU opA=5, opB=0 -> done and div_by_zero high 2 cycles after start; HI=0x5, LO=0xFFFFFFFF; next op has div_by_zero=0.
REQ-030 Reset at cycle 10 of a MULT -> busy=0 and HI/LO=0 next cycle, no done pulse; subsequent MULTU 3x4 -> LO=0xC, HI=0.
REQ-031 start with new operands while busy -> ignored; result equals the first operation; held outputs unchanged until its done.
REQ-032 WIDTH=8: MULT 0x80 x 0x80 -> HI=0x40, LO=0x00, done 10 cycles after start; DIV 0x80 / 0xFF -> LO=0x80, HI=0x00.
